// File: rtl/dsp_peak_holder_mc.sv
// Multi-channel windowed peak detector with per-channel peak-hold/decay meter.
// Optional sticky clip detection is built only when DSP_PEAK_CLIP_EN is defined.
module dsp_peak_holder_mc #(
  parameter int CH          = 2,
  parameter int W           = 16,
  parameter int HOLD_FRAMES = 8,
  parameter int DECAY_SHIFT = 3
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic [CH*W-1:0]   iIn,
  input  logic              iValid,
  input  logic              iFrame,
  input  logic              iMode,
  input  logic              iClipClr,
  output logic [CH*W-1:0]   oOut,
  output logic              oValid,
  output logic [CH*(W-1)-1:0] oHold,
  output logic [CH-1:0]     oClip,
  output logic [CH-1:0]     oDbgState
);

  // Handshake: iValid qualifies iIn for one cycle, iFrame closes the window for
  // one cycle; oValid pulses exactly once, the cycle after iFrame. No backpressure.

  localparam int CW = $clog2(HOLD_FRAMES + 1);
  localparam logic [W-2:0] MAG_ONE = {{(W-2){1'b0}}, 1'b1};

  typedef enum logic {ST_HOLD = 1'b0, ST_DECAY = 1'b1} hold_st_e;

  function automatic logic [W-2:0] mag(input logic [W-1:0] x);
    logic [W-1:0] t;
    t = x[W-1] ? ~x : x;
    return t[W-2:0];
  endfunction

  logic            mode_q, mode_d;
  logic            valid_q, valid_d;
  logic [W-1:0]    win_q [CH];
  logic [W-1:0]    win_d [CH];
  logic [W-1:0]    out_q [CH];
  logic [W-1:0]    out_d [CH];
  logic [W-2:0]    h_q   [CH];
  logic [W-2:0]    h_d   [CH];
  logic [CW-1:0]   cnt_q [CH];
  logic [CW-1:0]   cnt_d [CH];
  hold_st_e        st_q  [CH];
  hold_st_e        st_d  [CH];

  logic [W-1:0]    samp;
  logic [W-2:0]    p;
  logic [W-2:0]    step;
  logic [W-2:0]    dec_h;

  always_comb begin
    mode_d  = iFrame ? iMode : mode_q;
    valid_d = iFrame;
    samp    = '0;
    p       = '0;
    step    = '0;
    dec_h   = '0;
    for (int c = 0; c < CH; c++) begin
      samp  = iIn[c*W +: W];
      p     = mag(win_q[c]);
      step  = h_q[c] >> DECAY_SHIFT;
      if (step == '0) step = MAG_ONE;
      dec_h = h_q[c] - step;
      win_d[c] = win_q[c];
      out_d[c] = out_q[c];
      h_d[c]   = h_q[c];
      cnt_d[c] = cnt_q[c];
      st_d[c]  = st_q[c];
      if (iFrame) begin
        // A sample coinciding with the frame strobe belongs to the new window.
        win_d[c] = iValid ? samp : '0;
        out_d[c] = mode_q ? win_q[c] : {1'b0, p};
        if (p >= h_q[c]) begin
          h_d[c]   = p;
          cnt_d[c] = CW'(HOLD_FRAMES);
          st_d[c]  = ST_HOLD;
        end else if (st_q[c] == ST_HOLD) begin
          if (cnt_q[c] != '0) cnt_d[c] = cnt_q[c] - CW'(1);
          else                st_d[c]  = ST_DECAY;
        end else begin
          h_d[c] = (dec_h > p) ? dec_h : p;
        end
      end else if (iValid && (mag(samp) > p)) begin
        win_d[c] = samp;
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      mode_q  <= 1'b0;
      valid_q <= 1'b0;
      for (int c = 0; c < CH; c++) begin
        win_q[c] <= '0;
        out_q[c] <= '0;
        h_q[c]   <= '0;
        cnt_q[c] <= '0;
        st_q[c]  <= ST_HOLD;
      end
    end else begin
      mode_q  <= mode_d;
      valid_q <= valid_d;
      for (int c = 0; c < CH; c++) begin
        win_q[c] <= win_d[c];
        out_q[c] <= out_d[c];
        h_q[c]   <= h_d[c];
        cnt_q[c] <= cnt_d[c];
        st_q[c]  <= st_d[c];
      end
    end
  end

  assign oValid = valid_q;

  for (genvar g = 0; g < CH; g++) begin : g_pack
    assign oOut[g*W +: W]          = out_q[g];
    assign oHold[g*(W-1) +: (W-1)] = h_q[g];
    assign oDbgState[g]            = (st_q[g] == ST_DECAY);
  end

`ifdef DSP_PEAK_CLIP_EN
  localparam logic [W-1:0] S_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] S_MIN = {1'b1, {(W-1){1'b0}}};

  logic [CH-1:0] clip_q, clip_d;
  logic [W-1:0]  clip_s;

  // A clip in the same cycle as a clear wins, so no clip event is ever lost.
  always_comb begin
    clip_d = iClipClr ? '0 : clip_q;
    clip_s = '0;
    for (int c = 0; c < CH; c++) begin
      clip_s = iIn[c*W +: W];
      if (iValid && ((clip_s == S_MAX) || (clip_s == S_MIN))) clip_d[c] = 1'b1;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) clip_q <= '0;
    else         clip_q <= clip_d;
  end

  assign oClip = clip_q;
`else
  logic unused_clip_clr;
  assign unused_clip_clr = iClipClr;
  assign oClip = '0;
`endif

endmodule

// File: tb/tb_dsp_peak_holder_mc.sv
// Self-checking bench for dsp_peak_holder_mc: directed steps plus random windows
// compared against a sample-list reference model.
module tb_dsp_peak_holder_mc;

  localparam int CH = 2;
  localparam int W  = 16;
  localparam int HF = 3;
  localparam int DS = 2;

  logic              iCLK;
  logic              iRST_N;
  logic [CH*W-1:0]   iIn;
  logic              iValid;
  logic              iFrame;
  logic              iMode;
  logic              iClipClr;
  logic [CH*W-1:0]   oOut;
  logic              oValid;
  logic [CH*(W-1)-1:0] oHold;
  logic [CH-1:0]     oClip;
  logic [CH-1:0]     oDbgState;

  int total = 0;
  int bad   = 0;

  dsp_peak_holder_mc #(.CH(CH), .W(W), .HOLD_FRAMES(HF), .DECAY_SHIFT(DS)) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iIn(iIn), .iValid(iValid), .iFrame(iFrame),
    .iMode(iMode), .iClipClr(iClipClr), .oOut(oOut), .oValid(oValid),
    .oHold(oHold), .oClip(oClip), .oDbgState(oDbgState)
  );

  // clock / reset
  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  // reference model: windows kept as plain sample lists
  int      wq0[$];
  int      wq1[$];
  bit      mode_m;
  int      hold_m [2];
  int      cnt_m  [2];
  bit      dec_m  [2];
  int      out_m  [2];
  bit [1:0] clip_m;

  function automatic int mag_i(input int x);
    return (x < 0) ? (-x - 1) : x;
  endfunction

  function automatic int win_best(input int q[$]);
    int best;
    best = q[0];
    foreach (q[i]) if (mag_i(q[i]) > mag_i(best)) best = q[i];
    return best;
  endfunction

  task automatic model_reset();
    wq0 = {};
    wq1 = {};
    wq0.push_back(0);
    wq1.push_back(0);
    mode_m = 1'b0;
    clip_m = 2'b00;
    for (int c = 0; c < 2; c++) begin
      hold_m[c] = 0; cnt_m[c] = 0; dec_m[c] = 1'b0; out_m[c] = 0;
    end
  endtask

  task automatic hold_update(input int c, input int pk);
    int st;
    if (pk >= hold_m[c]) begin
      hold_m[c] = pk; cnt_m[c] = HF; dec_m[c] = 1'b0;
    end else if (!dec_m[c]) begin
      if (cnt_m[c] > 0) cnt_m[c] = cnt_m[c] - 1;
      else              dec_m[c] = 1'b1;
    end else begin
      st = hold_m[c] / (1 << DS);
      if (st < 1) st = 1;
      hold_m[c] = (hold_m[c] - st > pk) ? hold_m[c] - st : pk;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver: one clock of stimulus, model update, then check after the edge
  task automatic step(input bit v, input bit f, input bit m, input bit clr,
                      input int s0, input int s1);
    int b0, b1;
    logic [15:0] a0, a1;
    a0 = 16'(s0);
    a1 = 16'(s1);
    iIn      = {a1, a0};
    iValid   = v;
    iFrame   = f;
    iMode    = m;
    iClipClr = clr;
`ifdef DSP_PEAK_CLIP_EN
    if (clr) clip_m = 2'b00;
    if (v && (s0 == 32767 || s0 == -32768)) clip_m[0] = 1'b1;
    if (v && (s1 == 32767 || s1 == -32768)) clip_m[1] = 1'b1;
`endif
    if (f) begin
      b0 = win_best(wq0);
      b1 = win_best(wq1);
      out_m[0] = mode_m ? b0 : mag_i(b0);
      out_m[1] = mode_m ? b1 : mag_i(b1);
      hold_update(0, mag_i(b0));
      hold_update(1, mag_i(b1));
      wq0 = {};
      wq1 = {};
      wq0.push_back(v ? s0 : 0);
      wq1.push_back(v ? s1 : 0);
      mode_m = m;
    end else if (v) begin
      wq0.push_back(s0);
      wq1.push_back(s1);
    end
    @(posedge iCLK);
    #1;
    chk("ovalid", {31'b0, oValid}, {31'b0, f});
    if (f) begin
      chk("out0",  {16'b0, oOut[15:0]},  {16'b0, 16'(out_m[0])});
      chk("out1",  {16'b0, oOut[31:16]}, {16'b0, 16'(out_m[1])});
      chk("hold0", {17'b0, oHold[14:0]},  32'(hold_m[0]));
      chk("hold1", {17'b0, oHold[29:15]}, 32'(hold_m[1]));
      chk("state", {30'b0, oDbgState},    {30'b0, dec_m[1], dec_m[0]});
    end
    chk("clip", {30'b0, oClip}, {30'b0, clip_m});
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_out"},   oOut,                 32'h0);
    chk({tag, "_valid"}, {31'b0, oValid},      32'h0);
    chk({tag, "_hold"},  {2'b0, oHold},        32'h0);
    chk({tag, "_clip"},  {30'b0, oClip},       32'h0);
    chk({tag, "_state"}, {30'b0, oDbgState},   32'h0);
  endtask

  function automatic int rnd_s();
    logic [15:0] r;
    r = 16'($urandom);
    return int'($signed(r));
  endfunction

  initial begin
    iRST_N = 1'b0; iIn = '0; iValid = 1'b0; iFrame = 1'b0;
    iMode = 1'b0; iClipClr = 1'b0;
    model_reset();
    #3;
    chk_all_zero("reset");
    #9;
    iRST_N = 1'b1;

    // mode 0 magnitude peak
    step(1, 0, 0, 0, 100,  rnd_s());
    step(1, 0, 0, 0, -300, rnd_s());
    step(1, 0, 0, 0, 250,  rnd_s());
    step(0, 1, 1, 0, 0, 0);
    chk("m0_299", {16'b0, oOut[15:0]}, 32'd299);
    step(0, 0, 1, 0, 0, 0);

    // mode 1 signed peak, then empty window
    step(1, 0, 1, 0, rnd_s(), 200);
    step(1, 0, 1, 0, rnd_s(), -500);
    step(1, 0, 1, 0, rnd_s(), 499);
    step(0, 1, 1, 0, 0, 0);
    chk("m1_neg500", {16'b0, oOut[31:16]}, 32'h0000_FE0C);
    step(0, 1, 0, 0, 0, 0);
    chk("m1_empty", {16'b0, oOut[31:16]}, 32'h0);

    // sample coincident with frame seeds the new window
    step(1, 1, 0, 0, 7000, -7000);
    step(1, 0, 0, 0, 100, -100);
    step(0, 1, 0, 0, 0, 0);
    chk("seed7000", {16'b0, oOut[15:0]}, 32'd7000);

    // random windows
    for (int i = 0; i < 300; i++) begin
      int s0, s1;
      s0 = rnd_s();
      s1 = rnd_s();
      if ($urandom_range(0, 15) == 0) s0 = 32767;
      if ($urandom_range(0, 15) == 0) s1 = -32768;
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0),
           1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), s0, s1);
    end

    // drain the meter, then a 1024 peak held and decayed to 0
    for (int i = 0; i < 60; i++) step(0, 1, 0, 1, 0, 0);
    step(1, 0, 0, 0, 1024, 0);
    step(0, 1, 0, 0, 0, 0);
    chk("peak1024", {17'b0, oHold[14:0]}, 32'd1024);
    for (int i = 0; i < 45; i++) step(0, 1, 0, 0, 0, 0);
    chk("decay_to0", {17'b0, oHold[14:0]}, 32'd0);

    // reset mid-window and mid-decay
    step(1, 0, 0, 0, 20000, -20000);
    step(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 5000, 5000);
    #2;
    iRST_N = 1'b0;
    #1;
    chk_all_zero("async_rst");
    model_reset();
    #4;
    iRST_N = 1'b1;
    step(1, 0, 0, 0, 321, -42);
    step(0, 1, 0, 0, 0, 0);
    chk("post_rst", {16'b0, oOut[15:0]}, 32'd321);

    // clip flag behaviour (stays 0 when clip logic is not built)
    step(1, 0, 0, 0, -32768, 5);
    step(0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 1, 32767, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
